// File: rtl/decrypt_message.sv
// RC4 keystream generator (PRGA) and decryption stage: walks the scrambled S RAM, XORs each
// keystream byte with the encrypted ROM and writes the plaintext RAM. Optional: DECRYPT_ASCII_CHECK_EN.
module decrypt_message #(
    parameter int MSG_LEN = 32,
    localparam int AW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start_decrypt,
    input  logic [7:0]    s_q,
    input  logic [7:0]    rom_q,
    output logic [7:0]    s_address,
    output logic [7:0]    s_data,
    output logic          s_wren,
    output logic [AW-1:0] rom_address,
    output logic [AW-1:0] dec_address,
    output logic [7:0]    dec_data,
    output logic          dec_wren,
    output logic          done_decrypt,
    output logic          key_invalid
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_INC_I,
        S_WAIT_I,
        S_READ_I,
        S_ADDR_J,
        S_WAIT_J,
        S_READ_J,
        S_WRITE_J,
        S_WRITE_I,
        S_ADDR_F,
        S_WAIT_F,
        S_READ_F,
        S_NEXT_K,
        S_DONE
    } state_t;

    localparam logic [AW-1:0] LAST_K = AW'(MSG_LEN - 1);

    state_t        state, state_next;
    logic [7:0]    i, i_next;
    logic [7:0]    j, j_next;
    logic [AW-1:0] k, k_next;
    logic [7:0]    temp_i, temp_i_next;
    logic [7:0]    temp_j, temp_j_next;
    logic [7:0]    f, f_next;
    logic [7:0]    s_addr_r, s_addr_next;
    logic [AW-1:0] rom_addr_r, rom_addr_next;
    logic          key_bad_r, key_bad_next;

`ifdef DECRYPT_ASCII_CHECK_EN
    // Plaintext is expected to be lowercase letters and spaces only.
    function automatic logic is_plain(input logic [7:0] b);
        return ((b >= 8'h61) && (b <= 8'h7A)) || (b == 8'h20);
    endfunction
`endif

    always_comb begin
        // NOTE: every signal driven here gets a default first so no path can infer a latch.
        state_next    = state;
        i_next        = i;
        j_next        = j;
        k_next        = k;
        temp_i_next   = temp_i;
        temp_j_next   = temp_j;
        f_next        = f;
        s_addr_next   = s_addr_r;
        rom_addr_next = rom_addr_r;
        key_bad_next  = key_bad_r;

        s_address     = s_addr_r;
        s_data        = 8'h00;
        s_wren        = 1'b0;
        dec_address   = '0;
        dec_data      = 8'h00;
        dec_wren      = 1'b0;
        done_decrypt  = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (start_decrypt) begin
                    i_next       = 8'h00;
                    j_next       = 8'h00;
                    k_next       = '0;
                    key_bad_next = 1'b0;
                    state_next   = S_INC_I;
                end
            end
            S_INC_I: begin
                i_next      = i + 8'd1;
                s_addr_next = i + 8'd1;
                state_next  = S_WAIT_I;
            end
            S_WAIT_I: state_next = S_READ_I;
            S_READ_I: begin
                temp_i_next = s_q;
                j_next      = j + s_q;
                state_next  = S_ADDR_J;
            end
            S_ADDR_J: begin
                s_addr_next = j;
                state_next  = S_WAIT_J;
            end
            S_WAIT_J: state_next = S_READ_J;
            S_READ_J: begin
                temp_j_next = s_q;
                state_next  = S_WRITE_J;
            end
            // When i == j both writes store the same byte, leaving S unchanged there.
            S_WRITE_J: begin
                s_address  = j;
                s_data     = temp_i;
                s_wren     = 1'b1;
                state_next = S_WRITE_I;
            end
            S_WRITE_I: begin
                s_address  = i;
                s_data     = temp_j;
                s_wren     = 1'b1;
                state_next = S_ADDR_F;
            end
            S_ADDR_F: begin
                s_addr_next   = temp_i + temp_j;
                rom_addr_next = k;
                state_next    = S_WAIT_F;
            end
            S_WAIT_F: state_next = S_READ_F;
            S_READ_F: begin
                f_next     = s_q ^ rom_q;
                state_next = S_NEXT_K;
            end
            S_NEXT_K: begin
                dec_address = k;
                dec_data    = f;
                dec_wren    = 1'b1;
`ifdef DECRYPT_ASCII_CHECK_EN
                if (!is_plain(f)) begin
                    key_bad_next = 1'b1;
                    state_next   = S_DONE;
                end else
`endif
                if (k == LAST_K) begin
                    state_next = S_DONE;
                end else begin
                    k_next     = k + 1'b1;
                    state_next = S_INC_I;
                end
            end
            S_DONE: begin
                done_decrypt = 1'b1;
                state_next   = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so every register
    // samples the values from before the edge regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            i          <= 8'h00;
            j          <= 8'h00;
            k          <= '0;
            temp_i     <= 8'h00;
            temp_j     <= 8'h00;
            f          <= 8'h00;
            s_addr_r   <= 8'h00;
            rom_addr_r <= '0;
            key_bad_r  <= 1'b0;
        end else begin
            state      <= state_next;
            i          <= i_next;
            j          <= j_next;
            k          <= k_next;
            temp_i     <= temp_i_next;
            temp_j     <= temp_j_next;
            f          <= f_next;
            s_addr_r   <= s_addr_next;
            rom_addr_r <= rom_addr_next;
            key_bad_r  <= key_bad_next;
        end
    end

    assign rom_address = rom_addr_r;

`ifdef DECRYPT_ASCII_CHECK_EN
    assign key_invalid = key_bad_r;
`else
    assign key_invalid = 1'b0;
`endif

endmodule

// File: tb/tb_decrypt_message.sv
// Self-checking bench for decrypt_message: behavioural S RAM / ROM / plaintext RAM, directed
// vector tables and a software RC4 reference for the golden-key runs.
module tb_decrypt_message;

    localparam int MSG_LEN = 32;
    localparam int AW      = $clog2(MSG_LEN);
    localparam int FULL    = 12 * MSG_LEN;

    logic          clk = 1'b0;
    logic          reset;
    logic          start_decrypt;
    logic [7:0]    s_q, rom_q;
    logic [7:0]    s_address, s_data;
    logic          s_wren;
    logic [AW-1:0] rom_address, dec_address;
    logic [7:0]    dec_data;
    logic          dec_wren, done_decrypt, key_invalid;

    decrypt_message #(.MSG_LEN(MSG_LEN)) dut (
        .clk          (clk),
        .reset        (reset),
        .start_decrypt(start_decrypt),
        .s_q          (s_q),
        .rom_q        (rom_q),
        .s_address    (s_address),
        .s_data       (s_data),
        .s_wren       (s_wren),
        .rom_address  (rom_address),
        .dec_address  (dec_address),
        .dec_data     (dec_data),
        .dec_wren     (dec_wren),
        .done_decrypt (done_decrypt),
        .key_invalid  (key_invalid)
    );

    always #5 clk = ~clk;

    // Memory models: one-cycle read latency; bulk preload/clear requested by flags.
    logic [7:0] s_mem   [256];
    logic [7:0] s_init  [256];
    logic [7:0] rom_mem [MSG_LEN];
    logic [7:0] rom_init[MSG_LEN];
    logic [7:0] dec_mem [MSG_LEN];
    logic       mem_load = 1'b0;

    always @(posedge clk) begin
        s_q   <= s_mem[s_address];
        rom_q <= rom_mem[rom_address];
        if (mem_load) begin
            for (int n = 0; n < 256; n++) s_mem[n] <= s_init[n];
            for (int n = 0; n < MSG_LEN; n++) begin
                rom_mem[n] <= rom_init[n];
                dec_mem[n] <= 8'h00;
            end
        end else begin
            if (s_wren)   s_mem[s_address]     <= s_data;
            if (dec_wren) dec_mem[dec_address] <= dec_data;
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic load_mems();
        mem_load = 1'b1;
        @(posedge clk); #1;
        mem_load = 1'b0;
    endtask

    // Reference RC4: key schedule for key 0x000249, then PRGA keystream.
    logic [7:0] ks[MSG_LEN];
    logic [7:0] pt[MSG_LEN];

    task automatic ksa_fill();
        logic [7:0] key_b[3];
        logic [7:0] jj, t;
        key_b[0] = 8'h00; key_b[1] = 8'h02; key_b[2] = 8'h49;
        for (int n = 0; n < 256; n++) s_init[n] = 8'(n);
        jj = 8'h00;
        for (int n = 0; n < 256; n++) begin
            jj = jj + s_init[n] + key_b[n % 3];
            t = s_init[n]; s_init[n] = s_init[jj]; s_init[jj] = t;
        end
    endtask

    task automatic rc4_keystream();
        logic [7:0] sm[256];
        logic [7:0] ii, jj, t;
        for (int n = 0; n < 256; n++) sm[n] = s_init[n];
        ii = 8'h00; jj = 8'h00;
        for (int n = 0; n < MSG_LEN; n++) begin
            ii = ii + 8'd1;
            jj = jj + sm[ii];
            t = sm[ii]; sm[ii] = sm[jj]; sm[jj] = t;
            t = sm[ii] + sm[jj];
            ks[n] = sm[t];
        end
    endtask

    // Pulse start (the following edge is E0) and observe cycles E0+c, sampled 1 ns after each edge.
    task automatic run_decrypt(input int busy_at, input int reset_at, input bit probe_s1,
                               output int done_cyc, output int pulses, output int writes,
                               output int post_rst_wr, output logic inv_at_done);
        done_cyc = -1; pulses = 0; writes = 0; post_rst_wr = 0; inv_at_done = 1'b0;
        start_decrypt = 1'b1;
        @(posedge clk); #1;
        start_decrypt = 1'b0;
        for (int c = 1; c <= 500; c++) begin
            if (c == busy_at)     start_decrypt = 1'b1;
            if (c == busy_at + 1) start_decrypt = 1'b0;
            if (reset_at > 0 && c == reset_at)     reset = 1'b1;
            if (reset_at > 0 && c == reset_at + 1) reset = 1'b0;
            @(posedge clk); #1;
            if (dec_wren) writes++;
            if (done_decrypt) begin
                pulses++;
                if (done_cyc < 0) begin
                    done_cyc    = c;
                    inv_at_done = key_invalid;
                end
            end
            if (reset_at > 0 && c >= reset_at && (s_wren || dec_wren)) post_rst_wr++;
            if (probe_s1 && c == 12) check("id_s1_after_byte0", 32'(s_mem[1]), 32'h01);
            if (done_cyc > 0 && c >= done_cyc + 20) break;
            if (reset_at > 0 && c >= reset_at + 100) break;
        end
    endtask

    typedef struct {
        string      name;
        int         addr;
        logic [7:0] exp;
    } vec_t;

    vec_t id_vec[3];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         done_cyc, pulses, writes, post_rst_wr, wr_seen, bad;
        logic       inv;
        string      pt_str;

        // Identity-S vectors: keystream bytes 2, 5, 7 for bytes 0..2.
        id_vec[0] = '{"id_dec0", 0, 8'h02};
`ifdef DECRYPT_ASCII_CHECK_EN
        id_vec[1] = '{"id_dec1_unwritten", 1, 8'h00};
        id_vec[2] = '{"id_dec2_unwritten", 2, 8'h00};
`else
        id_vec[1] = '{"id_dec1", 1, 8'h05};
        id_vec[2] = '{"id_dec2", 2, 8'h07};
`endif

        pt_str = "the quick brown fox jumps over a";
        for (int n = 0; n < MSG_LEN; n++) pt[n] = pt_str[n];

        // Reset behaviour and quiescence with start low.
        reset = 1'b1; start_decrypt = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_s_address",   32'(s_address),   32'h0);
        check("rst_s_data",      32'(s_data),      32'h0);
        check("rst_s_wren",      32'(s_wren),      32'h0);
        check("rst_rom_address", 32'(rom_address), 32'h0);
        check("rst_dec_address", 32'(dec_address), 32'h0);
        check("rst_dec_data",    32'(dec_data),    32'h0);
        check("rst_dec_wren",    32'(dec_wren),    32'h0);
        check("rst_done",        32'(done_decrypt), 32'h0);
        check("rst_key_invalid", 32'(key_invalid), 32'h0);
        reset = 1'b0;
        wr_seen = 0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            if (s_wren || dec_wren || done_decrypt) wr_seen++;
        end
        check("idle_no_activity", 32'(wr_seen), 32'h0);

        // Identity S, zero ROM.
        for (int n = 0; n < 256; n++) s_init[n] = 8'(n);
        for (int n = 0; n < MSG_LEN; n++) rom_init[n] = 8'h00;
        load_mems();
        run_decrypt(0, 0, 1'b1, done_cyc, pulses, writes, post_rst_wr, inv);
        for (int v = 0; v < 3; v++) check(id_vec[v].name, 32'(dec_mem[id_vec[v].addr]), 32'(id_vec[v].exp));
        check("id_done_pulses", 32'(pulses), 32'h1);
`ifdef DECRYPT_ASCII_CHECK_EN
        check("id_done_cycle",       32'(done_cyc), 32'd12);
        check("id_inv_at_done",      32'(inv),      32'h1);
        check("id_dec_writes",       32'(writes),   32'h1);
        check("id_inv_held",         32'(key_invalid), 32'h1);
`else
        check("id_done_cycle",       32'(done_cyc), 32'(FULL));
        check("id_inv_at_done",      32'(inv),      32'h0);
        check("id_dec_writes",       32'(writes),   32'(MSG_LEN));
        check("id_inv_held",         32'(key_invalid), 32'h0);
`endif

        // Golden key: S from key 0x000249, ROM = plaintext XOR reference keystream.
        ksa_fill();
        rc4_keystream();
        for (int n = 0; n < MSG_LEN; n++) rom_init[n] = pt[n] ^ ks[n];
        load_mems();
        run_decrypt(0, 0, 1'b0, done_cyc, pulses, writes, post_rst_wr, inv);
        for (int n = 0; n < MSG_LEN; n++) check($sformatf("gold_dec%0d", n), 32'(dec_mem[n]), 32'(pt[n]));
        check("gold_done_cycle",  32'(done_cyc), 32'(FULL));
        check("gold_done_pulses", 32'(pulses),   32'h1);
        check("gold_key_invalid", 32'(inv),      32'h0);
        check("gold_dec_writes",  32'(writes),   32'(MSG_LEN));

        // Start pulsed mid-run must be ignored.
        load_mems();
        run_decrypt(30, 0, 1'b0, done_cyc, pulses, writes, post_rst_wr, inv);
        bad = 0;
        for (int n = 0; n < MSG_LEN; n++) if (dec_mem[n] !== pt[n]) bad++;
        check("busy_dec_errors",  32'(bad),      32'h0);
        check("busy_done_cycle",  32'(done_cyc), 32'(FULL));
        check("busy_done_pulses", 32'(pulses),   32'h1);

        // Reset at cycle 50 aborts; then re-scramble and rerun.
        load_mems();
        run_decrypt(0, 50, 1'b0, done_cyc, pulses, writes, post_rst_wr, inv);
        check("rstmid_writes_after", 32'(post_rst_wr), 32'h0);
        check("rstmid_no_done",      32'(pulses),      32'h0);
        load_mems();
        run_decrypt(0, 0, 1'b0, done_cyc, pulses, writes, post_rst_wr, inv);
        bad = 0;
        for (int n = 0; n < MSG_LEN; n++) if (dec_mem[n] !== pt[n]) bad++;
        check("rerun_dec_errors",  32'(bad),      32'h0);
        check("rerun_done_cycle",  32'(done_cyc), 32'(FULL));
        check("rerun_done_pulses", 32'(pulses),   32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
